arbitro_paralelo_serial: RTL and testbench

ARBITRO_PARALELO_SERIAL -- requirements
Module: arbitro_paralelo_serial

---
 rtl/arbitro_paralelo_serial.sv | 147 ++++++++++++++
 tb/tb_arbitro_paralelo_serial.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/arbitro_paralelo_serial.sv
// Round-robin arbiter feeding a byte serializer.
// Emits NUM_COM_INIT idle (COM) slots after reset, then one byte per 8-cycle slot.
module arbitro_paralelo_serial #(
  parameter int NUM_COM_INIT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [3:0] valid_in,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  output logic [3:0] pop,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] grant,
  output logic       active
);

  localparam logic [7:0] COM   = 8'hBC;
  localparam logic [3:0] TLAST = 4'(NUM_COM_INIT - 1);

  typedef enum logic {
    TRAIN,
    ACTIVE
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [3:0] r_tcnt;
  logic [1:0] r_ptr;
  logic [1:0] r_grant;
  logic [3:0] r_pop;
  logic       r_valid;
  logic [7:0] r_data;

  state_t     w_state_n;
  logic [3:0] w_tcnt_n;
  logic [1:0] w_ptr_n;
  logic [1:0] w_grant_n;
  logic [3:0] w_pop_n;
  logic       w_valid_n;
  logic [7:0] w_data_n;

  logic       w_boundary;
  logic       w_arb;
  logic [3:0] w_rot;
  logic       w_hit;
  logic [1:0] w_off;
  logic [1:0] w_win;
  logic [7:0] w_win_data;

  assign w_boundary = (r_cnt == 3'd7);

  // Requests rotated so that bit 0 is the requester at the pointer.
  always_comb begin
    w_rot = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_rot[k] = valid_in[r_ptr + 2'(k)];
    end
  end

  always_comb begin
    w_hit = 1'b1;
    w_off = 2'd0;
    priority case (1'b1)
      w_rot[0]: w_off = 2'd0;
      w_rot[1]: w_off = 2'd1;
      w_rot[2]: w_off = 2'd2;
      w_rot[3]: w_off = 2'd3;
      default:  w_hit = 1'b0;
    endcase
  end

  assign w_win = r_ptr + w_off;

  always_comb begin
    w_win_data = data_in0;
    unique case (w_win)
      2'd0: w_win_data = data_in0;
      2'd1: w_win_data = data_in1;
      2'd2: w_win_data = data_in2;
      2'd3: w_win_data = data_in3;
      default: w_win_data = data_in0;
    endcase
  end

  // Last training boundary already carries the first arbitrated slot.
  assign w_arb = (r_state == ACTIVE) || (r_tcnt == TLAST);

  always_comb begin
    w_state_n = r_state;
    w_tcnt_n  = r_tcnt;
    w_ptr_n   = r_ptr;
    w_grant_n = r_grant;
    w_pop_n   = 4'b0000;
    w_valid_n = r_valid;
    w_data_n  = r_data;
    if (w_boundary) begin
      if (r_state == TRAIN) begin
        w_tcnt_n = r_tcnt + 4'd1;
        if (r_tcnt == TLAST) begin
          w_state_n = ACTIVE;
        end
      end
      if (w_arb && w_hit) begin
        w_data_n  = w_win_data;
        w_valid_n = 1'b1;
        w_grant_n = w_win;
        w_pop_n   = 4'b0001 << w_win;
        w_ptr_n   = w_win + 2'd1;
      end else begin
        w_data_n  = COM;
        w_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state <= TRAIN;
      r_cnt   <= 3'd0;
      r_tcnt  <= 4'd0;
      r_ptr   <= 2'd0;
      r_grant <= 2'd0;
      r_pop   <= 4'b0000;
      r_valid <= 1'b0;
      r_data  <= COM;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= r_cnt + 3'd1;
      r_tcnt  <= w_tcnt_n;
      r_ptr   <= w_ptr_n;
      r_grant <= w_grant_n;
      r_pop   <= w_pop_n;
      r_valid <= w_valid_n;
      r_data  <= w_data_n;
    end
  end

  assign pop       = r_pop;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign grant     = r_grant;
  assign active    = (r_state == ACTIVE);

endmodule

// File: tb/tb_arbitro_paralelo_serial.sv
// Directed bench for arbitro_paralelo_serial.
// Slot-by-slot expectations computed by hand.
module tb_arbitro_paralelo_serial;

  logic       clk_32f;
  logic       reset;
  logic [3:0] valid_in;
  logic [7:0] data_in0;
  logic [7:0] data_in1;
  logic [7:0] data_in2;
  logic [7:0] data_in3;
  logic [3:0] pop;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] grant;
  logic       active;

  int n_chk = 0;
  int n_err = 0;

  arbitro_paralelo_serial #(.NUM_COM_INIT(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .valid_in (valid_in),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .pop      (pop),
    .data_out (data_out),
    .valid_out(valid_out),
    .grant    (grant),
    .active   (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one 8-edge slot starting at cnt==0; hold is the byte of the
  // current slot, the rest describe the slot started at the boundary.
  task automatic slot(input string tag, input logic [7:0] hold,
                      input logic [3:0] p, input logic v,
                      input logic [7:0] d, input logic [1:0] g,
                      input logic a);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk({tag, "_mid_pop"}, {4'b0, pop}, 8'h00);
      chk({tag, "_mid_data"}, data_out, hold);
    end
    tick();
    chk({tag, "_pop"}, {4'b0, pop}, {4'b0, p});
    chk({tag, "_valid"}, {7'b0, valid_out}, {7'b0, v});
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_grant"}, {6'b0, grant}, {6'b0, g});
    chk({tag, "_active"}, {7'b0, active}, {7'b0, a});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pop"}, {4'b0, pop}, 8'h00);
    chk({tag, "_valid"}, {7'b0, valid_out}, 8'h00);
    chk({tag, "_data"}, data_out, 8'hBC);
    chk({tag, "_grant"}, {6'b0, grant}, 8'h00);
    chk({tag, "_active"}, {7'b0, active}, 8'h00);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 4'b1111;
    data_in0 = 8'h11;
    data_in1 = 8'h22;
    data_in2 = 8'h33;
    data_in3 = 8'h44;
    #2 reset = 1'b0;
    tick();
    tick();
    chk_reset("rst");

    @(negedge clk_32f);
    reset = 1'b1;
    slot("trn1", 8'hBC, 4'b0000, 1'b0, 8'hBC, 2'd0, 1'b0);
    slot("trn2", 8'hBC, 4'b0000, 1'b0, 8'hBC, 2'd0, 1'b0);
    slot("trn3", 8'hBC, 4'b0000, 1'b0, 8'hBC, 2'd0, 1'b0);
    slot("first", 8'hBC, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);

    slot("rr1", 8'h11, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1);
    slot("rr2", 8'h22, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1);
    slot("rr3", 8'h33, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1);
    slot("rr0", 8'h44, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);

    valid_in = 4'b0000;
    slot("idle", 8'h11, 4'b0000, 1'b0, 8'hBC, 2'd0, 1'b1);
    valid_in = 4'b1111;
    slot("ptrkeep", 8'hBC, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1);
    valid_in = 4'b1000;
    slot("only3", 8'h22, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1);

    valid_in = 4'b0100;
    data_in2 = 8'hA5;
    slot("only2", 8'h44, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1);
    valid_in = 4'b1010;
    slot("ptr3", 8'hA5, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1);

    valid_in = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) valid_in = 4'b0010;
      if (i == 7) valid_in = 4'b0000;
      tick();
      chk("glitch_pop", {4'b0, pop}, 8'h00);
      if (i < 8) chk("glitch_hold", data_out, 8'h44);
    end
    chk("glitch_valid", {7'b0, valid_out}, 8'h00);
    chk("glitch_data", data_out, 8'hBC);
    chk("glitch_grant", {6'b0, grant}, 8'h03);

    valid_in = 4'b1111;
    slot("resume", 8'hBC, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);

    for (int i = 0; i < 4; i++) tick();
    #2 reset = 1'b0;
    #1 chk_reset("midrst");
    tick();
    chk_reset("midrst_hold");

    @(negedge clk_32f);
    reset = 1'b1;
    slot("re1", 8'hBC, 4'b0000, 1'b0, 8'hBC, 2'd0, 1'b0);
    slot("re2", 8'hBC, 4'b0000, 1'b0, 8'hBC, 2'd0, 1'b0);
    slot("re3", 8'hBC, 4'b0000, 1'b0, 8'hBC, 2'd0, 1'b0);
    slot("refirst", 8'hBC, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
